// File: rtl/norm_count_if.sv
// rtl/norm_count_if.sv - request/response handshake bundle for norm_count
//
// Purpose: groups the operand request channel and the result channel of the
// iterative count-leading-zeros/ones and normalize unit.
//
// Signals:
//   in_valid   request present (master -> slave)
//   in_ready   slave can accept a request (slave -> master)
//   in_x       32-bit operand
//   in_ones    0 = count leading zeros, 1 = count leading ones
//   out_valid  result present (slave -> master)
//   out_ready  master takes the result
//   out_count  leading-bit count, 0..32
//   out_norm   in_x shifted left by out_count, zero-filled
//
// Modports: master drives requests and consumes results; slave is the unit.

interface norm_count_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic        in_ones;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_count;
   logic [31:0] out_norm;

   modport master (
      output in_valid, in_x, in_ones, out_ready,
      input  in_ready, out_valid, out_count, out_norm
   );

   modport slave (
      input  in_valid, in_x, in_ones, out_ready,
      output in_ready, out_valid, out_count, out_norm
   );
endinterface

// File: rtl/norm_count.sv
// rtl/norm_count.sv - iterative CLZ/CLO and normalize unit, one nibble per cycle
//
// Purpose: derives the left-shift amount that normalizes a 32-bit operand
// (MIPS32 CLZ/CLO) and returns the normalized operand alongside it.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns the unit to IDLE
//   bus    norm_count_if.slave: in_valid/in_ready/in_x/in_ones request,
//          out_valid/out_ready/out_count/out_norm response

module norm_count (
   input  logic         clk,
   input  logic         reset,
   norm_count_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   state_t      state_next;

   // Working registers: w is the word being scanned (inverted for CLO),
   // norm tracks the original operand shifted by the same amount.
   logic [31:0] w;
   logic [31:0] norm;
   logic [5:0]  cnt;

   // Result registers only load on the BUSY->DONE edge, so the outputs keep
   // their last value through IDLE and the next BUSY phase.
   logic [5:0]  res_count;
   logic [31:0] res_norm;

   logic        accept;
   logic        top_zero;
   logic [1:0]  lz;

   assign top_zero      = (w[31:28] == 4'b0000);
   assign bus.out_count = res_count;
   assign bus.out_norm  = res_norm;

   // Leading zeros within a non-zero top nibble.
   always_comb begin
      lz = 2'd3;
      casez (w[31:28])
         4'b1???: lz = 2'd0;
         4'b01??: lz = 2'd1;
         4'b001?: lz = 2'd2;
         default: lz = 2'd3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            // Finish on a non-zero nibble, or after the eighth all-zero nibble.
            if (!top_zero || cnt >= 6'd28) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w         <= 32'd0;
         norm      <= 32'd0;
         cnt       <= 6'd0;
         res_count <= 6'd0;
         res_norm  <= 32'd0;
      end else if (accept) begin
         w    <= bus.in_ones ? ~bus.in_x : bus.in_x;
         norm <= bus.in_x;
         cnt  <= 6'd0;
      end else if (state == BUSY) begin
         if (top_zero && cnt < 6'd28) begin
            w    <= w << 4;
            norm <= norm << 4;
            cnt  <= cnt + 6'd4;
         end else if (top_zero) begin
            // All 32 bits were leading bits: every bit shifts out.
            cnt       <= 6'd32;
            norm      <= 32'd0;
            res_count <= 6'd32;
            res_norm  <= 32'd0;
         end else begin
            cnt       <= cnt + {4'd0, lz};
            norm      <= norm << lz;
            res_count <= cnt + {4'd0, lz};
            res_norm  <= norm << lz;
         end
      end
   end

endmodule

// File: tb/tb_norm_count.sv
// tb/tb_norm_count.sv - self-checking bench for norm_count

module tb_norm_count;

   logic clk;
   logic reset;

   norm_count_if bus ();

   norm_count dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] x;
      bit          ones;
      int          cnt;
      logic [31:0] norm;
      int          k;
      int          stall;
      bit          holdoff;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: walk the bits from the MSB and count matching leading bits.
   function automatic int ref_count(input logic [31:0] x, input bit ones);
      int n;
      n = 0;
      while (n < 32 && x[31 - n] == ones) n++;
      return n;
   endfunction

   function automatic logic [31:0] ref_norm(input logic [31:0] x, input int n);
      logic [63:0] wide;
      wide = {32'd0, x} << n;
      return wide[31:0];
   endfunction

   function automatic int ref_k(input int n);
      return (n == 32) ? 8 : (n / 4 + 1);
   endfunction

   // Runs one request from IDLE through the response handshake.
   // Called #1 after a rising edge; returns #1 after a rising edge.
   task automatic run_op(input string name, input logic [31:0] x, input bit ones,
                         input int exp_cnt, input logic [31:0] exp_norm, input int exp_k,
                         input int stall, input bit holdoff);
      int k;
      chk({name, ":in_ready_idle"}, {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b1;
      bus.in_x     = x;
      bus.in_ones  = ones;
      @(posedge clk);
      #1;
      if (holdoff) begin
         bus.in_valid = 1'b1;
         bus.in_x     = ~x ^ 32'h5a5a_0f0f;
         bus.in_ones  = ~ones;
      end else begin
         bus.in_valid = 1'b0;
         bus.in_x     = $urandom;
      end
      k = 0;
      while (bus.out_valid !== 1'b1 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({name, ":out_valid"}, {63'd0, bus.out_valid}, 64'd1);
      chk({name, ":latency"}, 64'(k), 64'(exp_k));
      chk({name, ":count"}, {58'd0, bus.out_count}, 64'(exp_cnt));
      chk({name, ":norm"}, {32'd0, bus.out_norm}, {32'd0, exp_norm});
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk({name, ":stall_valid"}, {63'd0, bus.out_valid}, 64'd1);
         chk({name, ":stall_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
         chk({name, ":stall_count"}, {58'd0, bus.out_count}, 64'(exp_cnt));
         chk({name, ":stall_norm"}, {32'd0, bus.out_norm}, {32'd0, exp_norm});
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk({name, ":in_ready_after"}, {63'd0, bus.in_ready}, 64'd1);
      chk({name, ":out_valid_after"}, {63'd0, bus.out_valid}, 64'd0);
      chk({name, ":count_held"}, {58'd0, bus.out_count}, 64'(exp_cnt));
   endtask

   initial begin
      logic [31:0] x;
      bit          ones;
      int          n;
      int          sh;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{32'h8000_0000, 1'b0, 0,  32'h8000_0000, 1, 5, 1'b0};
      vecs[1]  = '{32'h0000_0001, 1'b0, 31, 32'h8000_0000, 8, 0, 1'b1};
      vecs[2]  = '{32'h0000_0000, 1'b0, 32, 32'h0000_0000, 8, 1, 1'b0};
      vecs[3]  = '{32'hFFF0_1234, 1'b1, 12, 32'h0123_4000, 4, 0, 1'b1};
      vecs[4]  = '{32'hFFFF_FFFF, 1'b1, 32, 32'h0000_0000, 8, 2, 1'b1};
      vecs[5]  = '{32'h0F00_0000, 1'b0, 4,  32'hF000_0000, 2, 0, 1'b0};
      vecs[6]  = '{32'h7FFF_FFFF, 1'b1, 0,  32'h7FFF_FFFF, 1, 0, 1'b0};
      vecs[7]  = '{32'h8000_0000, 1'b1, 1,  32'h0000_0000, 1, 0, 1'b1};
      vecs[8]  = '{32'h0000_0010, 1'b0, 27, 32'h8000_0000, 7, 0, 1'b0};
      vecs[9]  = '{32'h0000_0008, 1'b0, 28, 32'h8000_0000, 8, 0, 1'b0};
      vecs[10] = '{32'h2000_0000, 1'b0, 2,  32'h8000_0000, 1, 0, 1'b1};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_x      = 32'd0;
      bus.in_ones   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset:in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("reset:out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("reset:out_count", {58'd0, bus.out_count}, 64'd0);
      chk("reset:out_norm", {32'd0, bus.out_norm}, 64'd0);

      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].ones, vecs[i].cnt,
                vecs[i].norm, vecs[i].k, vecs[i].stall, vecs[i].holdoff);
      end

      // Reset on the second BUSY cycle of a long operation.
      bus.in_valid = 1'b1;
      bus.in_x     = 32'h0000_00FF;
      bus.in_ones  = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset:in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("midreset:out_valid", {63'd0, bus.out_valid}, 64'd0);
      run_op("after_reset", 32'h0F00_0000, 1'b0, 4, 32'hF000_0000, 2, 0, 1'b0);

      // Randomized pass against the reference model.
      for (int i = 0; i < 2000; i++) begin
         ones = 1'($urandom_range(0, 1));
         sh   = $urandom_range(0, 32);
         x    = (sh == 32) ? 32'd0 : ($urandom >> sh);
         if (ones) x = ~x;
         n = ref_count(x, ones);
         run_op($sformatf("rand%0d_x%08h_o%0d", i, x, ones), x, ones, n,
                ref_norm(x, n), ref_k(n), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         chk($sformatf("rand%0d:norm_shift", i), {32'd0, bus.out_norm},
             {32'd0, ref_norm(x, int'(bus.out_count))});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
